id_exe_pipe_reg: RTL and testbench

- Parametrised ID->EXE pipeline register for the vector processor, replacing the fixed-width always-load ID/EXE latch.
- Adds a valid/ready handshake, downstream stall (hold), hazard flush (bubble insertion) and multi-cycle vector sequencing.
- A vector instruction occupies EXE for NUM_ELEM cycles while an element index is issued; decode is back-pressured until the last element.
- Sits between the decoder/hazard unit and the ALU/vector lanes.

---
 rtl/id_exe_pipe_reg.sv | 192 +++++++++++++++++++
 tb/tb_id_exe_pipe_reg.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_exe_pipe_reg.sv
// ID->EXE pipeline register with valid/ready handshake, stall, flush and
// multi-cycle vector element sequencing.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   flush             squash EXE contents and the incoming ID instruction
//   exe_stall         downstream hold; all state frozen
//   id_valid/id_ready ID handshake (id_ready is combinational, ignores id_valid)
//   id_*              decoded instruction fields and controls from ID
//   exe_valid         EXE holds a live instruction
//   exe_*             registered copies of the ID fields
//   exe_elem_idx      current vector element, exe_elem_last on final element
//   state, cnt_o      registered decoder FSM state / counter pass-through
module id_exe_pipe_reg #(
  parameter int unsigned PC_W     = 16,
  parameter int unsigned IMM_W    = 32,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned NUM_ELEM = 4,
  parameter int unsigned IDX_W    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             exe_stall,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [PC_W-1:0]  id_pc,
  input  logic [4:0]       id_rt_addr,
  input  logic [4:0]       id_rd_addr,
  input  logic [4:0]       id_shamt,
  input  logic [5:0]       id_funct,
  input  logic [IMM_W-1:0] id_immd,
  input  logic             id_reg_dst,
  input  logic             id_reg_write,
  input  logic             id_mem_to_reg,
  input  logic             id_alu_src,
  input  logic             id_branch,
  input  logic             id_vreg_write,
  input  logic             id_mem_write_n,
  input  logic [1:0]       id_alu_op,
  input  logic             id_is_vector,
  input  logic [1:0]       id_next_state,
  input  logic [CNT_W-1:0] id_cnt,
  output logic             exe_valid,
  output logic [PC_W-1:0]  exe_pc,
  output logic [4:0]       exe_rt_addr,
  output logic [4:0]       exe_rd_addr,
  output logic [4:0]       exe_shamt,
  output logic [5:0]       exe_funct,
  output logic [IMM_W-1:0] exe_immd,
  output logic             exe_reg_dst,
  output logic             exe_reg_write,
  output logic             exe_mem_to_reg,
  output logic             exe_alu_src,
  output logic             exe_branch,
  output logic             exe_vreg_write,
  output logic             exe_mem_write_n,
  output logic [1:0]       exe_alu_op,
  output logic [IDX_W-1:0] exe_elem_idx,
  output logic             exe_elem_last,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cnt_o
);

  typedef enum logic [1:0] {StEmpty, StScalar, StVec} st_e;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [4:0]       rt_addr;
    logic [4:0]       rd_addr;
    logic [4:0]       shamt;
    logic [5:0]       funct;
    logic [IMM_W-1:0] immd;
    logic             reg_dst;
    logic             reg_write;
    logic             mem_to_reg;
    logic             alu_src;
    logic             branch;
    logic             vreg_write;
    logic             mem_write_n;
    logic [1:0]       alu_op;
  } exe_t;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_ELEM - 1);

  st_e              st_q, st_d;
  exe_t             exe_q, exe_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic is_last;
  logic can_leave;
  logic load;

  assign is_last   = (idx_q == LastIdx);
  // EXE can accept a new instruction once the current one has finished its last cycle.
  assign can_leave = (st_q == StEmpty) || (st_q == StScalar) || ((st_q == StVec) && is_last);
  assign id_ready  = ~exe_stall & ~flush & can_leave;
  assign load      = id_valid & id_ready;

  always_comb begin
    st_d    = st_q;
    exe_d   = exe_q;
    idx_d   = idx_q;
    state_d = state_q;
    cnt_d   = cnt_q;

    if (!exe_stall) begin
      state_d = id_next_state;
      cnt_d   = id_cnt;
    end

    if (flush) begin
      st_d              = StEmpty;
      idx_d             = '0;
      exe_d.reg_write   = 1'b0;
      exe_d.vreg_write  = 1'b0;
      exe_d.branch      = 1'b0;
      exe_d.mem_to_reg  = 1'b0;
      exe_d.mem_write_n = 1'b1;
    end else if (exe_stall) begin
      // hold everything
    end else if (load) begin
      exe_d.pc          = id_pc;
      exe_d.rt_addr     = id_rt_addr;
      exe_d.rd_addr     = id_rd_addr;
      exe_d.shamt       = id_shamt;
      exe_d.funct       = id_funct;
      exe_d.immd        = id_immd;
      exe_d.reg_dst     = id_reg_dst;
      exe_d.reg_write   = id_reg_write;
      exe_d.mem_to_reg  = id_mem_to_reg;
      exe_d.alu_src     = id_alu_src;
      exe_d.branch      = id_branch;
      exe_d.vreg_write  = id_vreg_write;
      exe_d.mem_write_n = id_mem_write_n;
      exe_d.alu_op      = id_alu_op;
      idx_d             = '0;
      st_d              = (id_is_vector && (NUM_ELEM > 1)) ? StVec : StScalar;
    end else if (can_leave) begin
      // Bubble: controls go inert, datapath fields keep their last value.
      st_d              = StEmpty;
      exe_d.reg_write   = 1'b0;
      exe_d.vreg_write  = 1'b0;
      exe_d.branch      = 1'b0;
      exe_d.mem_to_reg  = 1'b0;
      exe_d.mem_write_n = 1'b1;
    end else begin
      // Only reachable in StVec before the last element.
      idx_d = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q              <= StEmpty;
      exe_q             <= '0;
      exe_q.mem_write_n <= 1'b1;
      idx_q             <= '0;
      state_q           <= '0;
      cnt_q             <= '0;
    end else begin
      st_q    <= st_d;
      exe_q   <= exe_d;
      idx_q   <= idx_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign exe_valid       = (st_q != StEmpty);
  assign exe_pc          = exe_q.pc;
  assign exe_rt_addr     = exe_q.rt_addr;
  assign exe_rd_addr     = exe_q.rd_addr;
  assign exe_shamt       = exe_q.shamt;
  assign exe_funct       = exe_q.funct;
  assign exe_immd        = exe_q.immd;
  assign exe_reg_dst     = exe_q.reg_dst;
  assign exe_reg_write   = exe_q.reg_write;
  assign exe_mem_to_reg  = exe_q.mem_to_reg;
  assign exe_alu_src     = exe_q.alu_src;
  assign exe_branch      = exe_q.branch;
  assign exe_vreg_write  = exe_q.vreg_write;
  assign exe_mem_write_n = exe_q.mem_write_n;
  assign exe_alu_op      = exe_q.alu_op;
  assign exe_elem_idx    = idx_q;
  assign exe_elem_last   = is_last || (st_q != StVec);
  assign state           = state_q;
  assign cnt_o           = cnt_q;

endmodule

// File: tb/tb_id_exe_pipe_reg.sv
module tb_id_exe_pipe_reg;

  logic        clk = 1'b0;
  logic        rst, flush, exe_stall, id_valid, id_ready;
  logic [15:0] id_pc;
  logic [4:0]  id_rt_addr, id_rd_addr, id_shamt;
  logic [5:0]  id_funct;
  logic [31:0] id_immd;
  logic        id_reg_dst, id_reg_write, id_mem_to_reg, id_alu_src, id_branch, id_vreg_write;
  logic        id_mem_write_n, id_is_vector;
  logic [1:0]  id_alu_op, id_next_state;
  logic [31:0] id_cnt;
  logic        exe_valid;
  logic [15:0] exe_pc;
  logic [4:0]  exe_rt_addr, exe_rd_addr, exe_shamt;
  logic [5:0]  exe_funct;
  logic [31:0] exe_immd;
  logic        exe_reg_dst, exe_reg_write, exe_mem_to_reg, exe_alu_src, exe_branch;
  logic        exe_vreg_write, exe_mem_write_n;
  logic [1:0]  exe_alu_op, state;
  logic [1:0]  exe_elem_idx;
  logic        exe_elem_last;
  logic [31:0] cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_exe_pipe_reg #(
    .PC_W(16), .IMM_W(32), .CNT_W(32), .NUM_ELEM(4), .IDX_W(2)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .exe_stall(exe_stall),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr), .id_shamt(id_shamt),
    .id_funct(id_funct), .id_immd(id_immd), .id_reg_dst(id_reg_dst),
    .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src),
    .id_branch(id_branch), .id_vreg_write(id_vreg_write), .id_mem_write_n(id_mem_write_n),
    .id_alu_op(id_alu_op), .id_is_vector(id_is_vector), .id_next_state(id_next_state),
    .id_cnt(id_cnt), .exe_valid(exe_valid), .exe_pc(exe_pc), .exe_rt_addr(exe_rt_addr),
    .exe_rd_addr(exe_rd_addr), .exe_shamt(exe_shamt), .exe_funct(exe_funct),
    .exe_immd(exe_immd), .exe_reg_dst(exe_reg_dst), .exe_reg_write(exe_reg_write),
    .exe_mem_to_reg(exe_mem_to_reg), .exe_alu_src(exe_alu_src), .exe_branch(exe_branch),
    .exe_vreg_write(exe_vreg_write), .exe_mem_write_n(exe_mem_write_n),
    .exe_alu_op(exe_alu_op), .exe_elem_idx(exe_elem_idx), .exe_elem_last(exe_elem_last),
    .state(state), .cnt_o(cnt_o)
  );

  // Advance past the next rising edge; outputs are sampled 2 units after it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Drive an ID instruction with fixed side fields; controls are all "active".
  task automatic drive_id(input logic v, input logic [15:0] pc, input logic vec,
                          input logic [1:0] ns, input logic [31:0] cnt);
    id_valid       = v;
    id_pc          = pc;
    id_rt_addr     = 5'd3;
    id_rd_addr     = 5'd5;
    id_shamt       = 5'd2;
    id_funct       = 6'h20;
    id_immd        = {16'h1234, pc};
    id_reg_dst     = 1'b1;
    id_reg_write   = 1'b1;
    id_mem_to_reg  = 1'b1;
    id_alu_src     = 1'b1;
    id_branch      = 1'b1;
    id_vreg_write  = vec;
    id_mem_write_n = 1'b0;
    id_alu_op      = 2'd2;
    id_is_vector   = vec;
    id_next_state  = ns;
    id_cnt         = cnt;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; exe_stall = 1'b0;
    drive_id(1'b1, 16'h00ee, 1'b0, 2'd3, 32'hdead);
    tick(); tick();
    n_checks++; if (exe_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", exe_valid); end
    n_checks++; if (exe_pc !== 16'h0) begin n_fail++; $display("FAIL reset_pc: got %h exp 0", exe_pc); end
    n_checks++; if (exe_mem_write_n !== 1'b1) begin n_fail++; $display("FAIL reset_mwn: got %b exp 1", exe_mem_write_n); end
    n_checks++; if ({exe_reg_write, exe_branch, exe_vreg_write, exe_immd} !== 35'h0) begin
      n_fail++; $display("FAIL reset_ctl: got %b%b%b imm %h exp zeros", exe_reg_write, exe_branch, exe_vreg_write, exe_immd); end
    n_checks++; if ({state, cnt_o, exe_elem_idx} !== 36'h0) begin
      n_fail++; $display("FAIL reset_state: got st %0d cnt %h idx %0d exp 0", state, cnt_o, exe_elem_idx); end
    id_valid = 1'b0;
    rst = 1'b0;
    #1;
    n_checks++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b exp 1", id_ready); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] pcs [3];
    pcs[0] = 16'h0010; pcs[1] = 16'h0014; pcs[2] = 16'h0018;
    for (int i = 0; i < 3; i++) begin
      drive_id(1'b1, pcs[i], 1'b0, 2'd1, 32'(i));
      #1;
      n_checks++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b exp 1", i, id_ready); end
      tick();
      n_checks++; if (exe_pc !== pcs[i] || exe_valid !== 1'b1) begin
        n_fail++; $display("FAIL b2b_pc[%0d]: got %h v%b exp %h v1", i, exe_pc, exe_valid, pcs[i]); end
      n_checks++; if (exe_elem_last !== 1'b1 || exe_mem_write_n !== 1'b0 || exe_immd !== {16'h1234, pcs[i]}) begin
        n_fail++; $display("FAIL b2b_fields[%0d]: got last %b mwn %b imm %h", i, exe_elem_last, exe_mem_write_n, exe_immd); end
    end
    id_valid = 1'b0;
    tick();
  endtask

  task automatic test_vector();
    drive_id(1'b1, 16'h0040, 1'b1, 2'd0, 32'd0);
    tick();
    drive_id(1'b1, 16'h0044, 1'b0, 2'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (exe_elem_idx !== 2'(i) || exe_pc !== 16'h0040 || exe_vreg_write !== 1'b1) begin
        n_fail++; $display("FAIL vec_idx[%0d]: got idx %0d pc %h vw %b exp %0d 0040 1", i, exe_elem_idx, exe_pc, exe_vreg_write, i); end
      n_checks++; if (id_ready !== (i == 3) || exe_elem_last !== (i == 3)) begin
        n_fail++; $display("FAIL vec_ready[%0d]: got rdy %b last %b exp %b", i, id_ready, exe_elem_last, i == 3); end
      tick();
    end
    n_checks++; if (exe_pc !== 16'h0044 || exe_elem_idx !== 2'd0 || exe_vreg_write !== 1'b0 || exe_elem_last !== 1'b1) begin
      n_fail++; $display("FAIL vec_next_scalar: got pc %h idx %0d vw %b last %b exp 0044 0 0 1", exe_pc, exe_elem_idx, exe_vreg_write, exe_elem_last); end
    id_valid = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    drive_id(1'b1, 16'h0060, 1'b1, 2'd1, 32'd7);
    tick();
    id_valid = 1'b0;
    tick();
    n_checks++; if (exe_elem_idx !== 2'd1) begin n_fail++; $display("FAIL stall_pre: got idx %0d exp 1", exe_elem_idx); end
    drive_id(1'b1, 16'h0070, 1'b0, 2'd2, 32'h99);
    exe_stall = 1'b1;
    #1;
    n_checks++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready: got %b exp 0", id_ready); end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (exe_elem_idx !== 2'd1 || exe_pc !== 16'h0060 || exe_valid !== 1'b1) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got idx %0d pc %h v %b exp 1 0060 1", i, exe_elem_idx, exe_pc, exe_valid); end
      n_checks++; if (state !== 2'd1 || cnt_o !== 32'd7) begin
        n_fail++; $display("FAIL stall_state[%0d]: got st %0d cnt %h exp 1 7", i, state, cnt_o); end
    end
    exe_stall = 1'b0;
    id_valid  = 1'b0;
    tick();
    n_checks++; if (exe_elem_idx !== 2'd2 || state !== 2'd2 || cnt_o !== 32'h99) begin
      n_fail++; $display("FAIL stall_resume: got idx %0d st %0d cnt %h exp 2 2 99", exe_elem_idx, state, cnt_o); end
    tick();
    tick();
    n_checks++; if (exe_valid !== 1'b0 || exe_vreg_write !== 1'b0) begin
      n_fail++; $display("FAIL stall_drain: got v %b vw %b exp 0 0", exe_valid, exe_vreg_write); end
  endtask

  task automatic test_flush();
    drive_id(1'b1, 16'h0080, 1'b1, 2'd0, 32'd0);
    tick();
    id_valid = 1'b0;
    tick();
    tick();
    n_checks++; if (exe_elem_idx !== 2'd2 || exe_mem_write_n !== 1'b0) begin
      n_fail++; $display("FAIL flush_pre: got idx %0d mwn %b exp 2 0", exe_elem_idx, exe_mem_write_n); end
    drive_id(1'b1, 16'h0090, 1'b0, 2'd0, 32'd0);
    flush = 1'b1; exe_stall = 1'b1;
    #1;
    n_checks++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b exp 0", id_ready); end
    tick();
    n_checks++; if (exe_valid !== 1'b0 || exe_elem_idx !== 2'd0) begin
      n_fail++; $display("FAIL flush_valid: got v %b idx %0d exp 0 0", exe_valid, exe_elem_idx); end
    n_checks++; if ({exe_reg_write, exe_vreg_write, exe_branch, exe_mem_to_reg, exe_mem_write_n} !== 5'b00001) begin
      n_fail++; $display("FAIL flush_ctl: got %b%b%b%b%b exp 00001", exe_reg_write, exe_vreg_write, exe_branch, exe_mem_to_reg, exe_mem_write_n); end
    n_checks++; if (exe_pc !== 16'h0080) begin n_fail++; $display("FAIL flush_drop: got pc %h exp 0080", exe_pc); end
    flush = 1'b0; exe_stall = 1'b0; id_valid = 1'b0;
    tick();
    n_checks++; if (exe_valid !== 1'b0 || exe_pc !== 16'h0080) begin
      n_fail++; $display("FAIL flush_after: got v %b pc %h exp 0 0080", exe_valid, exe_pc); end
  endtask

  task automatic test_bubble();
    drive_id(1'b1, 16'h00a0, 1'b0, 2'd1, 32'd3);
    tick();
    n_checks++; if (exe_valid !== 1'b1 || exe_reg_write !== 1'b1 || state !== 2'd1 || cnt_o !== 32'd3) begin
      n_fail++; $display("FAIL bubble_load: got v %b rw %b st %0d cnt %h exp 1 1 1 3", exe_valid, exe_reg_write, state, cnt_o); end
    drive_id(1'b0, 16'h00b0, 1'b0, 2'd2, 32'd5);
    tick();
    n_checks++; if (exe_valid !== 1'b0 || exe_pc !== 16'h00a0 || exe_rd_addr !== 5'd5) begin
      n_fail++; $display("FAIL bubble_hold: got v %b pc %h rd %0d exp 0 00a0 5", exe_valid, exe_pc, exe_rd_addr); end
    n_checks++; if ({exe_reg_write, exe_vreg_write, exe_branch, exe_mem_to_reg, exe_mem_write_n} !== 5'b00001) begin
      n_fail++; $display("FAIL bubble_ctl: got %b%b%b%b%b exp 00001", exe_reg_write, exe_vreg_write, exe_branch, exe_mem_to_reg, exe_mem_write_n); end
    n_checks++; if (state !== 2'd2 || cnt_o !== 32'd5) begin
      n_fail++; $display("FAIL bubble_state: got st %0d cnt %h exp 2 5", state, cnt_o); end
  endtask

  task automatic test_reset_mid_vec();
    drive_id(1'b1, 16'h00c0, 1'b1, 2'd3, 32'd11);
    tick();
    id_valid = 1'b0;
    tick();
    n_checks++; if (exe_elem_idx !== 2'd1) begin n_fail++; $display("FAIL rstvec_pre: got idx %0d exp 1", exe_elem_idx); end
    rst = 1'b1;
    tick();
    n_checks++; if (exe_valid !== 1'b0 || exe_pc !== 16'h0 || exe_elem_idx !== 2'd0 || exe_vreg_write !== 1'b0) begin
      n_fail++; $display("FAIL rstvec_out: got v %b pc %h idx %0d vw %b exp 0", exe_valid, exe_pc, exe_elem_idx, exe_vreg_write); end
    n_checks++; if (exe_mem_write_n !== 1'b1 || state !== 2'd0 || cnt_o !== 32'd0) begin
      n_fail++; $display("FAIL rstvec_misc: got mwn %b st %0d cnt %h exp 1 0 0", exe_mem_write_n, state, cnt_o); end
    rst = 1'b0;
    #1;
    n_checks++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL rstvec_ready: got %b exp 1", id_ready); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_vector();
    test_stall();
    test_flush();
    test_bubble();
    test_reset_mid_vec();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
